lap_timer: RTL and testbench
============================

# lap_timer

Parametrised min:sec stopwatch with a multi-slot lap buffer, run/pause/saturate control and switch-driven value editing. It is the next generation of the Basys3 clock block: counting advances on an external 1 Hz `tick` strobe from the divider, and laps are held in an N-deep ordered buffer instead of a single holder register. The seven-segment driver consumes its BCD digit outputs.

## Interface
Parameters:
- `LAPS`, 4: lap buffer depth, 2..16.
- `MIN_MAX`, 99: largest minute value, 1..99.
- `SEC_MAX`, 59: largest second value, 1..99.

Ports:
- `clk` in 1: system clock (100 MHz).
- `rst_n` in 1: synchronous, active-low reset.
- `tick` in 1: one-`clk` count strobe.
- `run` in 1: one-cycle start/stop pulse (debounced button).
- `lap` in 1: one-cycle lap-capture pulse.
- `clr` in 1: one-cycle clear pulse.
- `set_sec` in 1: one-cycle pulse that loads the seconds value.
- `set_min` in 1: one-cycle pulse that loads the minutes value.
- `set_val` in 7: value loaded by `set_sec` or `set_min`.
- `rd_idx` in $clog2(LAPS): lap slot to display; 0 is the oldest slot.
- `sec1`, `sec2`, `min1`, `min2` out 4 each: current time as BCD digits (ones, then tens).
- `lsec1`, `lsec2`, `lmin1`, `lmin2` out 4 each: lap `rd_idx` as BCD digits.
- `lap_count` out $clog2(LAPS)+1: number of valid laps.
- `full` out 1: `lap_count == LAPS`.
- `running` out 1: state is RUN.
- `sat` out 1: state is SAT.

## Operation
- The state machine has four states: IDLE, RUN, PAUSE, SAT. Reset enters IDLE.
- IDLE --`run`--> RUN.
- RUN --`run`--> PAUSE.
- PAUSE --`run`--> RUN.
- RUN --count reaches MIN_MAX:SEC_MAX--> SAT.
- SAT --`run`--> PAUSE.
- Any state --`clr`--> IDLE. A clear zeroes the current time, empties the lap buffer and sets `lap_count`=0.
- Counting happens on `tick` when the state at the clock edge is RUN:
  - Seconds increment normally.
  - At `sec`==SEC_MAX, `sec` returns to 0 and `min` increments.
  - At MIN_MAX:SEC_MAX the count holds and the state goes to SAT. The count never wraps to 00:00.
- Editing:
  - Edits are accepted only in IDLE or PAUSE and ignored in RUN and SAT.
  - `set_sec` loads `min(set_val, SEC_MAX)`.
  - `set_min` loads `min(set_val, MIN_MAX)`.
  - If both are asserted together, both loads happen.
  - Loading MIN_MAX:SEC_MAX in PAUSE does not enter SAT; the first RUN tick enters SAT without incrementing.
- Laps:
  - `lap` is accepted in RUN or SAT and writes the current time, as registered before the same-edge increment, into the next slot. `lap` is ignored in IDLE and PAUSE.
  - Slots are ordered oldest first; `rd_idx` counts from the oldest slot.
  - If `rd_idx >= lap_count`, the lap digits read 0.
- Priority within one cycle: `clr` > `set_*` > `lap` > `tick` increment > `run` transition.
- A `run` pulse and a `tick` on the same edge: the tick counts only if the pre-edge state is RUN. RUN→PAUSE therefore counts the tick; PAUSE→RUN does not.
- Widths:
  - Counters are 7 bits.
  - BCD digits are `value % 10` and `value / 10`, combinational from the registers.
  - Lap slots store 7+7 bits.

## Timing
- Reset values:
  - All digit outputs 0.
  - `lap_count`=0.
  - `full`, `running` and `sat` all 0.
  - Every lap slot 0.
- The current digits show an increment, set or clear one `clk` after the edge that samples it.
- `lap_count`, `full` and the stored slot are valid one `clk` after an accepted `lap`.
- Lap digit outputs are combinational from `rd_idx`, with zero-cycle read latency.
- `rst_n` low mid-count takes effect at the next edge, overriding every other input in that cycle.
- Inputs are single-cycle pulses. A level held high is acted on every cycle; edge detection belongs to the debouncer.

## Configuration
- `LAP_TIMER_WRAP_EN` defined: when `full`, an accepted `lap` overwrites the oldest slot. The buffer acts as a ring; `lap_count` stays at LAPS; `rd_idx`=0 now addresses the new oldest slot.
- `LAP_TIMER_WRAP_EN` undefined: when `full`, `lap` is dropped. Slots and `lap_count` are unchanged and `full` stays 1.

## Test plan
- Reset, `run`, then 61 `tick`s → digits show 01:01 and `running`=1. A further `run` gives `running`=0, and more ticks leave 01:01 unchanged.
- With MIN_MAX=2 and SEC_MAX=3, run 20 ticks → 02:03 with `sat`=1 (no wrap). A `run` pulse then gives PAUSE.
- In PAUSE, `set_val`=75 with `set_sec` → sec=59. `set_val`=5 with `set_min` → 05:59. The same pulses in RUN are ignored.
- LAPS=4: capture 5 laps at 00:01..00:05.
  - WRAP_EN: slots read 00:02..00:05 and `lap_count`=4.
  - Without WRAP_EN: slots read 00:01..00:04 and `full`=1.
- At 00:09 in RUN, assert `lap` and `tick` on the same edge → slot holds 00:09 and current shows 00:10.
- `clr` and `set_sec` in the same cycle → 00:00, IDLE, `lap_count`=0. `rst_n` low mid-run → all outputs 0 next edge.

Source files
------------

// File: rtl/lap_timer.sv
// lap_timer: min:sec stopwatch counting on an external 1 Hz tick.
// It has run/pause/saturate control, switch-driven editing and an ordered lap buffer.
// Optional feature macro: LAP_TIMER_WRAP_EN. When it is defined, a lap taken while
// the buffer is full overwrites the oldest slot, so the buffer acts as a ring.
// When it is undefined, such a lap is dropped.
module lap_timer #(
  parameter int LAPS    = 4,
  parameter int MIN_MAX = 99,
  parameter int SEC_MAX = 59
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    lap,
  input  logic                    clr,
  input  logic                    set_sec,
  input  logic                    set_min,
  input  logic [6:0]              set_val,
  input  logic [$clog2(LAPS)-1:0] rd_idx,
  output logic [3:0]              sec1,
  output logic [3:0]              sec2,
  output logic [3:0]              min1,
  output logic [3:0]              min2,
  output logic [3:0]              lsec1,
  output logic [3:0]              lsec2,
  output logic [3:0]              lmin1,
  output logic [3:0]              lmin2,
  output logic [$clog2(LAPS):0]   lap_count,
  output logic                    full,
  output logic                    running,
  output logic                    sat
);
  localparam int IW = $clog2(LAPS);
  localparam int CW = IW + 1;
  localparam logic [6:0]  SEC_TOP = 7'(SEC_MAX);
  localparam logic [6:0]  MIN_TOP = 7'(MIN_MAX);
  localparam logic [CW-1:0] DEPTH  = CW'(LAPS);
  localparam logic [CW:0]   LAPS_W = (CW+1)'(LAPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_SAT} state_t;

  state_t        state;
  logic [6:0]    sec_q, min_q;
  logic [6:0]    slot_sec [LAPS];
  logic [6:0]    slot_min [LAPS];
  logic [IW-1:0] head;
  logic [CW-1:0] cnt;

  logic          edit_ok, cap_ok, count_en, at_top, near_top, full_w;
  logic [IW-1:0] wr_idx, rd_phys;
  logic [6:0]    rd_sec, rd_min;

  // Clamp an edited value to the largest legal field value.
  function automatic logic [6:0] clamp(input logic [6:0] v, input logic [6:0] top);
    return (v > top) ? top : v;
  endfunction

  // Physical slot for a logical offset from the oldest slot (LAPS need not be 2^n).
  function automatic logic [IW-1:0] ring_idx(input logic [IW-1:0] base, input logic [CW-1:0] off);
    logic [CW:0] s;
    s = {2'b00, base} + {1'b0, off};
    if (s >= LAPS_W) s = s - LAPS_W;
    return IW'(s);
  endfunction

  function automatic logic [3:0] bcd_lo(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  function automatic logic [3:0] bcd_hi(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  assign edit_ok  = (state == S_IDLE) || (state == S_PAUSE);
  assign cap_ok   = (state == S_RUN) || (state == S_SAT);
  assign count_en = (state == S_RUN) && tick;
  assign at_top   = (sec_q == SEC_TOP) && (min_q == MIN_TOP);
  // The next increment lands on the top value, which ends the count.
  assign near_top = (sec_q == SEC_TOP - 7'd1) && (min_q == MIN_TOP);
  assign full_w   = (cnt == DEPTH);
  assign wr_idx   = ring_idx(head, cnt);

  // Control, counting, editing and lap capture; clr clears exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state <= S_IDLE;
      sec_q <= '0;
      min_q <= '0;
      head  <= '0;
      cnt   <= '0;
      for (int i = 0; i < LAPS; i++) begin
        slot_sec[i] <= '0;
        slot_min[i] <= '0;
      end
    end else begin
      if (edit_ok && set_sec) sec_q <= clamp(set_val, SEC_TOP);
      if (edit_ok && set_min) min_q <= clamp(set_val, MIN_TOP);

      // A lap stores the time as it stood before this edge's increment.
      if (lap && cap_ok) begin
        if (!full_w) begin
          slot_sec[wr_idx] <= sec_q;
          slot_min[wr_idx] <= min_q;
          cnt              <= cnt + CW'(1);
        end
`ifdef LAP_TIMER_WRAP_EN
        else begin
          slot_sec[head] <= sec_q;
          slot_min[head] <= min_q;
          head           <= ring_idx(head, CW'(1));
        end
`endif
      end

      if (count_en && !at_top) begin
        if (sec_q == SEC_TOP) begin
          sec_q <= '0;
          min_q <= min_q + 7'd1;
        end else begin
          sec_q <= sec_q + 7'd1;
        end
      end

      // Saturation on a tick takes precedence over a same-edge run pulse.
      unique case (state)
        S_IDLE:  if (run) state <= S_RUN;
        S_RUN: begin
          if (count_en && (at_top || near_top)) state <= S_SAT;
          else if (run)                         state <= S_PAUSE;
        end
        S_PAUSE: if (run) state <= S_RUN;
        S_SAT:   if (run) state <= S_PAUSE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lap readout: rd_idx counts from the oldest slot; slots not yet filled read as zero.
  always_comb begin
    rd_phys = ring_idx(head, {1'b0, rd_idx});
    rd_sec  = '0;
    rd_min  = '0;
    if ({1'b0, rd_idx} < cnt) begin
      rd_sec = slot_sec[rd_phys];
      rd_min = slot_min[rd_phys];
    end
  end

  assign sec1      = bcd_lo(sec_q);
  assign sec2      = bcd_hi(sec_q);
  assign min1      = bcd_lo(min_q);
  assign min2      = bcd_hi(min_q);
  assign lsec1     = bcd_lo(rd_sec);
  assign lsec2     = bcd_hi(rd_sec);
  assign lmin1     = bcd_lo(rd_min);
  assign lmin2     = bcd_hi(rd_min);
  assign lap_count = cnt;
  assign full      = full_w;
  assign running   = (state == S_RUN);
  assign sat       = (state == S_SAT);

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: two instances (default limits and MIN_MAX=2/SEC_MAX=3)
// share stimulus. Both are compared against a total-seconds / ordered-list model.
module tb_lap_timer;
  localparam int LAPS = 4;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, SAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1, tick = 1'b0, run = 1'b0, lap = 1'b0, clr = 1'b0;
  logic set_sec = 1'b0, set_min = 1'b0;
  logic [6:0] set_val = '0;
  logic [1:0] rd_idx = '0;

  logic [3:0] a_sec1, a_sec2, a_min1, a_min2, a_lsec1, a_lsec2, a_lmin1, a_lmin2;
  logic [3:0] b_sec1, b_sec2, b_min1, b_min2, b_lsec1, b_lsec2, b_lmin1, b_lmin2;
  logic [2:0] a_cnt, b_cnt;
  logic       a_full, a_run, a_sat, b_full, b_run, b_sat;

  int pass_cnt = 0, total_cnt = 0;

  int m_st [2];
  int m_sec[2];
  int m_min[2];
  int m_n  [2];
  int m_ls [2][LAPS];
  int m_lm [2][LAPS];
  int M_MAX[2] = '{99, 2};
  int S_MAX[2] = '{59, 3};

  always #5 clk = ~clk;

  lap_timer #(.LAPS(LAPS)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .lap(lap), .clr(clr),
    .set_sec(set_sec), .set_min(set_min), .set_val(set_val), .rd_idx(rd_idx),
    .sec1(a_sec1), .sec2(a_sec2), .min1(a_min1), .min2(a_min2),
    .lsec1(a_lsec1), .lsec2(a_lsec2), .lmin1(a_lmin1), .lmin2(a_lmin2),
    .lap_count(a_cnt), .full(a_full), .running(a_run), .sat(a_sat)
  );

  lap_timer #(.LAPS(LAPS), .MIN_MAX(2), .SEC_MAX(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .lap(lap), .clr(clr),
    .set_sec(set_sec), .set_min(set_min), .set_val(set_val), .rd_idx(rd_idx),
    .sec1(b_sec1), .sec2(b_sec2), .min1(b_min1), .min2(b_min2),
    .lsec1(b_lsec1), .lsec2(b_lsec2), .lmin1(b_lmin1), .lmin2(b_lmin2),
    .lap_count(b_cnt), .full(b_full), .running(b_run), .sat(b_sat)
  );

  logic [15:0] a_t, b_t, a_l, b_l;
  logic [5:0]  a_s, b_s;
  assign a_t = {a_min2, a_min1, a_sec2, a_sec1};
  assign b_t = {b_min2, b_min1, b_sec2, b_sec1};
  assign a_l = {a_lmin2, a_lmin1, a_lsec2, a_lsec1};
  assign b_l = {b_lmin2, b_lmin1, b_lsec2, b_lsec1};
  assign a_s = {a_cnt, a_full, a_run, a_sat};
  assign b_s = {b_cnt, b_full, b_run, b_sat};

  function automatic logic [15:0] bcd_time(input int mn, input int sc);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic logic [5:0] exp_status(input int d);
    return {3'(m_n[d]), m_n[d] == LAPS, m_st[d] == RUN, m_st[d] == SAT};
  endfunction

  function automatic logic [15:0] exp_lap(input int d, input int idx);
    if (idx >= m_n[d]) return 16'h0000;
    return bcd_time(m_lm[d][idx], m_ls[d][idx]);
  endfunction

  // Reference model: time as a total seconds count, laps as an ordered list.
  task automatic model_step(input int d);
    int ps, pm, t, top, span;
    bit hit;
    if (!rst_n || clr) begin
      m_st[d] = IDLE; m_sec[d] = 0; m_min[d] = 0; m_n[d] = 0;
      for (int i = 0; i < LAPS; i++) begin m_ls[d][i] = 0; m_lm[d][i] = 0; end
      return;
    end
    ps = m_sec[d]; pm = m_min[d]; hit = 1'b0;
    if (m_st[d] == IDLE || m_st[d] == PAUSE) begin
      if (set_sec) m_sec[d] = (int'(set_val) > S_MAX[d]) ? S_MAX[d] : int'(set_val);
      if (set_min) m_min[d] = (int'(set_val) > M_MAX[d]) ? M_MAX[d] : int'(set_val);
    end
    if ((m_st[d] == RUN || m_st[d] == SAT) && lap) begin
      if (m_n[d] < LAPS) begin
        m_ls[d][m_n[d]] = ps; m_lm[d][m_n[d]] = pm; m_n[d]++;
      end else begin
`ifdef LAP_TIMER_WRAP_EN
        for (int i = 0; i < LAPS - 1; i++) begin
          m_ls[d][i] = m_ls[d][i+1]; m_lm[d][i] = m_lm[d][i+1];
        end
        m_ls[d][LAPS-1] = ps; m_lm[d][LAPS-1] = pm;
`endif
      end
    end
    if (m_st[d] == RUN && tick) begin
      span = S_MAX[d] + 1;
      t    = pm * span + ps;
      top  = M_MAX[d] * span + S_MAX[d];
      if (t < top) t++;
      hit = (t == top);
      m_min[d] = t / span; m_sec[d] = t % span;
    end
    if (hit) m_st[d] = SAT;
    else if (run) begin
      case (m_st[d])
        IDLE:    m_st[d] = RUN;
        RUN:     m_st[d] = PAUSE;
        PAUSE:   m_st[d] = RUN;
        default: m_st[d] = PAUSE;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    rst_n = 1'b1; tick = 1'b0; run = 1'b0; lap = 1'b0; clr = 1'b0;
    set_sec = 1'b0; set_min = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin tick = 1'b1; step(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; tick = 1'b1; lap = 1'b1; set_sec = 1'b1; set_val = 7'd9;
    step();
    rd_idx = 2'd0; #1;
    total_cnt++; if (a_t !== 16'h0) $display("FAIL reset_time_a: got %h want %h", a_t, 16'h0); else pass_cnt++;
    total_cnt++; if (a_s !== 6'h0) $display("FAIL reset_status_a: got %h want %h", a_s, 6'h0); else pass_cnt++;
    total_cnt++; if (a_l !== 16'h0) $display("FAIL reset_lap_a: got %h want %h", a_l, 16'h0); else pass_cnt++;
    total_cnt++; if (b_t !== 16'h0 || b_s !== 6'h0) $display("FAIL reset_b: got %h/%h want 0000/00", b_t, b_s); else pass_cnt++;
  endtask

  task automatic test_run_count();
    do_reset();
    run = 1'b1; step();
    ticks(61);
    total_cnt++; if (a_t !== 16'h0101) $display("FAIL count_61: got %h want %h", a_t, 16'h0101); else pass_cnt++;
    total_cnt++; if (a_run !== 1'b1) $display("FAIL running_after_run: got %b want 1", a_run); else pass_cnt++;
    run = 1'b1; step();
    total_cnt++; if (a_run !== 1'b0) $display("FAIL pause_running: got %b want 0", a_run); else pass_cnt++;
    ticks(5);
    total_cnt++; if (a_t !== 16'h0101) $display("FAIL pause_hold: got %h want %h", a_t, 16'h0101); else pass_cnt++;
  endtask

  task automatic test_saturate();
    do_reset();
    run = 1'b1; step();
    ticks(20);
    total_cnt++; if (b_t !== 16'h0203) $display("FAIL sat_time: got %h want %h", b_t, 16'h0203); else pass_cnt++;
    total_cnt++; if ({b_sat, b_run} !== 2'b10) $display("FAIL sat_flag: got %b want 10", {b_sat, b_run}); else pass_cnt++;
    total_cnt++; if (a_t !== 16'h0020) $display("FAIL sat_other: got %h want %h", a_t, 16'h0020); else pass_cnt++;
    run = 1'b1; step();
    total_cnt++; if ({b_sat, b_run} !== 2'b00) $display("FAIL sat_to_pause: got %b want 00", {b_sat, b_run}); else pass_cnt++;
    ticks(1);
    total_cnt++; if (b_t !== 16'h0203) $display("FAIL sat_nowrap: got %h want %h", b_t, 16'h0203); else pass_cnt++;
  endtask

  task automatic test_edit();
    do_reset();
    run = 1'b1; step();
    run = 1'b1; step();
    set_val = 7'd75; set_sec = 1'b1; step();
    total_cnt++; if (a_t !== 16'h0059) $display("FAIL edit_sec_clamp: got %h want %h", a_t, 16'h0059); else pass_cnt++;
    set_val = 7'd5; set_min = 1'b1; step();
    total_cnt++; if (a_t !== 16'h0559) $display("FAIL edit_min: got %h want %h", a_t, 16'h0559); else pass_cnt++;
    total_cnt++; if (b_t !== 16'h0203 || b_sat !== 1'b0) $display("FAIL edit_top_nosat: got %h/%b want 0203/0", b_t, b_sat); else pass_cnt++;
    run = 1'b1; step();
    set_val = 7'd10; set_sec = 1'b1; step();
    set_val = 7'd1; set_min = 1'b1; step();
    total_cnt++; if (a_t !== 16'h0559) $display("FAIL edit_in_run: got %h want %h", a_t, 16'h0559); else pass_cnt++;
    ticks(1);
    total_cnt++; if (a_t !== 16'h0600) $display("FAIL edit_rollover: got %h want %h", a_t, 16'h0600); else pass_cnt++;
    total_cnt++; if (b_t !== 16'h0203 || b_sat !== 1'b1) $display("FAIL top_first_tick: got %h/%b want 0203/1", b_t, b_sat); else pass_cnt++;
  endtask

  task automatic test_laps();
    logic [15:0] want;
    do_reset();
    run = 1'b1; step();
    for (int k = 1; k <= 5; k++) begin
      ticks(1);
      lap = 1'b1; step();
      if (k == 2) begin
        total_cnt++; if (a_cnt !== 3'd2) $display("FAIL lap_count_2: got %0d want 2", a_cnt); else pass_cnt++;
        rd_idx = 2'd3; #1;
        total_cnt++; if (a_l !== 16'h0) $display("FAIL lap_unfilled: got %h want %h", a_l, 16'h0); else pass_cnt++;
      end
    end
    total_cnt++; if ({a_cnt, a_full} !== 4'b1001) $display("FAIL lap_full: got %b want 1001", {a_cnt, a_full}); else pass_cnt++;
    for (int i = 0; i < LAPS; i++) begin
      rd_idx = 2'(i); #1;
`ifdef LAP_TIMER_WRAP_EN
      want = 16'(i + 2);
`else
      want = 16'(i + 1);
`endif
      total_cnt++; if (a_l !== want) $display("FAIL lap_slot_%0d: got %h want %h", i, a_l, want); else pass_cnt++;
      total_cnt++; if (b_l !== exp_lap(1, i)) $display("FAIL lap_slot_b_%0d: got %h want %h", i, b_l, exp_lap(1, i)); else pass_cnt++;
    end
  endtask

  task automatic test_lap_tick();
    do_reset();
    run = 1'b1; step();
    ticks(9);
    lap = 1'b1; tick = 1'b1; step();
    rd_idx = 2'd0; #1;
    total_cnt++; if (a_l !== 16'h0009) $display("FAIL lap_pre_edge: got %h want %h", a_l, 16'h0009); else pass_cnt++;
    total_cnt++; if (a_t !== 16'h0010) $display("FAIL lap_same_tick: got %h want %h", a_t, 16'h0010); else pass_cnt++;
  endtask

  task automatic test_clr();
    lap = 1'b1; step();
    clr = 1'b1; set_sec = 1'b1; set_val = 7'd30; step();
    rd_idx = 2'd0; #1;
    total_cnt++; if (a_t !== 16'h0) $display("FAIL clr_time: got %h want %h", a_t, 16'h0); else pass_cnt++;
    total_cnt++; if (a_s !== 6'h0) $display("FAIL clr_status: got %h want %h", a_s, 6'h0); else pass_cnt++;
    total_cnt++; if (a_l !== 16'h0) $display("FAIL clr_lap: got %h want %h", a_l, 16'h0); else pass_cnt++;
    set_sec = 1'b1; set_val = 7'd30; step();
    total_cnt++; if (a_t !== 16'h0030) $display("FAIL idle_edit: got %h want %h", a_t, 16'h0030); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    run = 1'b1; step();
    ticks(7);
    lap = 1'b1; step();
    rst_n = 1'b0; run = 1'b1; tick = 1'b1; lap = 1'b1; step();
    rd_idx = 2'd0; #1;
    total_cnt++; if ({a_t, a_s, a_l} !== 38'h0) $display("FAIL rst_mid_a: got %h want 0", {a_t, a_s, a_l}); else pass_cnt++;
    total_cnt++; if ({b_t, b_s, b_l} !== 38'h0) $display("FAIL rst_mid_b: got %h want 0", {b_t, b_s, b_l}); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      tick    = ($urandom_range(0, 1) == 0);
      run     = ($urandom_range(0, 9) == 0);
      lap     = ($urandom_range(0, 5) == 0);
      clr     = ($urandom_range(0, 79) == 0);
      set_sec = ($urandom_range(0, 11) == 0);
      set_min = ($urandom_range(0, 11) == 0);
      set_val = 7'($urandom_range(0, 127));
      step();
      rd_idx = 2'($urandom_range(0, 3)); #1;
      total_cnt++;
      if (a_t !== bcd_time(m_min[0], m_sec[0]) || a_s !== exp_status(0) || a_l !== exp_lap(0, int'(rd_idx)))
        $display("FAIL rand_a cyc %0d: got %h/%h/%h want %h/%h/%h", n, a_t, a_s, a_l,
                 bcd_time(m_min[0], m_sec[0]), exp_status(0), exp_lap(0, int'(rd_idx)));
      else pass_cnt++;
      total_cnt++;
      if (b_t !== bcd_time(m_min[1], m_sec[1]) || b_s !== exp_status(1) || b_l !== exp_lap(1, int'(rd_idx)))
        $display("FAIL rand_b cyc %0d: got %h/%h/%h want %h/%h/%h", n, b_t, b_s, b_l,
                 bcd_time(m_min[1], m_sec[1]), exp_status(1), exp_lap(1, int'(rd_idx)));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_saturate();
    test_edit();
    test_laps();
    test_lap_tick();
    test_clr();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
